// File: rtl/jtag_axi_scratch_slave.sv
// AXI4 responder exposing a small 64-bit scratch register bank to the JTAG AXI master.
// Optional JTAG_SCRATCH_ID_WORD_EN: word 0 becomes a read-only identification constant.
module jtag_axi_scratch_slave #(
  parameter int unsigned NUM_WORDS = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned ID_W      = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [ID_W-1:0] aw_id_i,
  input  logic [31:0]     aw_addr_i,
  input  logic [7:0]      aw_len_i,
  input  logic [1:0]      aw_burst_i,
  input  logic            aw_valid_i,
  output logic            aw_ready_o,
  input  logic [63:0]     w_data_i,
  input  logic [7:0]      w_strb_i,
  input  logic            w_last_i,
  input  logic            w_valid_i,
  output logic            w_ready_o,
  output logic [ID_W-1:0] b_id_o,
  output logic [1:0]      b_resp_o,
  output logic            b_valid_o,
  input  logic            b_ready_i,
  output logic            b_user_o,
  input  logic [ID_W-1:0] ar_id_i,
  input  logic [31:0]     ar_addr_i,
  input  logic [7:0]      ar_len_i,
  input  logic [1:0]      ar_burst_i,
  input  logic            ar_valid_i,
  output logic            ar_ready_o,
  output logic [ID_W-1:0] r_id_o,
  output logic [63:0]     r_data_o,
  output logic [1:0]      r_resp_o,
  output logic            r_last_o,
  output logic            r_valid_o,
  input  logic            r_ready_i,
  output logic            r_user_o
);

  localparam int unsigned IDX_W  = 30;
  localparam int unsigned CNT_W  = 9;
  localparam int unsigned WORD_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [63:0] ID_WORD = 64'h4A54_4147_5343_5230;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
  typedef enum logic       {R_IDLE, R_DATA}         rstate_e;

  wstate_e           wstate_q, wstate_d;
  logic [ID_W-1:0]   wid_q, wid_d;
  logic [IDX_W-1:0]  widx_q, widx_d;
  logic [CNT_W-1:0]  wcnt_q, wcnt_d;
  logic              wfix_q, wfix_d;
  logic              werr_q, werr_d;
  logic              w_wr_en;
  logic              w_ok;

  rstate_e           rstate_q, rstate_d;
  logic [ID_W-1:0]   rid_q, rid_d;
  logic [IDX_W-1:0]  ridx_q, ridx_d;
  logic [CNT_W-1:0]  rcnt_q, rcnt_d;
  logic              rfix_q, rfix_d;
  logic              r_in_rng;
  logic [63:0]       r_word;

  logic [63:0]       mem_q [NUM_WORDS];

  // Byte offset from the base; the low three bits only select a byte inside a word.
  logic [31:0] aw_off, ar_off;
  logic [2:0]  unused_lsb;
  assign aw_off     = aw_addr_i - BASE_ADDR;
  assign ar_off     = ar_addr_i - BASE_ADDR;
  assign unused_lsb = aw_off[2:0] ^ ar_off[2:0];

`ifdef JTAG_SCRATCH_ID_WORD_EN
  assign w_ok = (widx_q < IDX_W'(NUM_WORDS)) && (widx_q != '0);
`else
  assign w_ok = (widx_q < IDX_W'(NUM_WORDS));
`endif

  // Write channel next-state
  always_comb begin
    wstate_d = wstate_q;
    wid_d    = wid_q;
    widx_d   = widx_q;
    wcnt_d   = wcnt_q;
    wfix_d   = wfix_q;
    werr_d   = werr_q;
    w_wr_en  = 1'b0;
    case (wstate_q)
      W_IDLE: begin
        if (aw_valid_i) begin
          wid_d    = aw_id_i;
          widx_d   = IDX_W'(aw_off[31:3]);
          wcnt_d   = CNT_W'(aw_len_i) + CNT_W'(1);
          wfix_d   = (aw_burst_i == 2'b00);
          werr_d   = 1'b0;
          wstate_d = W_DATA;
        end
      end
      W_DATA: begin
        if (w_valid_i) begin
          if (w_ok) w_wr_en = 1'b1;
          else      werr_d  = 1'b1;
          if (w_last_i || (wcnt_q == CNT_W'(1))) begin
            if (wcnt_q != CNT_W'(1)) werr_d = 1'b1;
            wstate_d = W_RESP;
          end else begin
            wcnt_d = wcnt_q - CNT_W'(1);
            if (!wfix_q) widx_d = widx_q + IDX_W'(1);
          end
        end
      end
      W_RESP: begin
        if (b_ready_i) begin
          werr_d   = 1'b0;
          wstate_d = W_IDLE;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  // Read channel next-state
  always_comb begin
    rstate_d = rstate_q;
    rid_d    = rid_q;
    ridx_d   = ridx_q;
    rcnt_d   = rcnt_q;
    rfix_d   = rfix_q;
    case (rstate_q)
      R_IDLE: begin
        if (ar_valid_i) begin
          rid_d    = ar_id_i;
          ridx_d   = IDX_W'(ar_off[31:3]);
          rcnt_d   = CNT_W'(ar_len_i) + CNT_W'(1);
          rfix_d   = (ar_burst_i == 2'b00);
          rstate_d = R_DATA;
        end
      end
      R_DATA: begin
        if (r_ready_i) begin
          if (rcnt_q == CNT_W'(1)) begin
            rstate_d = R_IDLE;
          end else begin
            rcnt_d = rcnt_q - CNT_W'(1);
            if (!rfix_q) ridx_d = ridx_q + IDX_W'(1);
          end
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wstate_q <= W_IDLE;
      wid_q    <= '0;
      widx_q   <= '0;
      wcnt_q   <= '0;
      wfix_q   <= 1'b0;
      werr_q   <= 1'b0;
      rstate_q <= R_IDLE;
      rid_q    <= '0;
      ridx_q   <= '0;
      rcnt_q   <= '0;
      rfix_q   <= 1'b0;
    end else begin
      wstate_q <= wstate_d;
      wid_q    <= wid_d;
      widx_q   <= widx_d;
      wcnt_q   <= wcnt_d;
      wfix_q   <= wfix_d;
      werr_q   <= werr_d;
      rstate_q <= rstate_d;
      rid_q    <= rid_d;
      ridx_q   <= ridx_d;
      rcnt_q   <= rcnt_d;
      rfix_q   <= rfix_d;
    end
  end

  // Scratch bank with per-byte write strobes
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_WORDS; i++) mem_q[i] <= '0;
    end else if (w_wr_en) begin
      for (int b = 0; b < 8; b++) begin
        if (w_strb_i[b]) mem_q[widx_q[WORD_W-1:0]][8*b +: 8] <= w_data_i[8*b +: 8];
      end
    end
  end

  assign r_in_rng = (ridx_q < IDX_W'(NUM_WORDS));

`ifdef JTAG_SCRATCH_ID_WORD_EN
  assign r_word = (ridx_q == '0) ? ID_WORD : mem_q[ridx_q[WORD_W-1:0]];
`else
  assign r_word = mem_q[ridx_q[WORD_W-1:0]];
`endif

  // Handshake readies are masked during reset so the bus sees all zeros.
  assign aw_ready_o = !rst_i && (wstate_q == W_IDLE);
  assign w_ready_o  = (wstate_q == W_DATA);
  assign b_valid_o  = (wstate_q == W_RESP);
  assign b_id_o     = wid_q;
  assign b_resp_o   = (b_valid_o && werr_q) ? 2'b10 : 2'b00;
  assign b_user_o   = 1'b0;

  assign ar_ready_o = !rst_i && (rstate_q == R_IDLE);
  assign r_valid_o  = (rstate_q == R_DATA);
  assign r_id_o     = rid_q;
  assign r_data_o   = (r_valid_o && r_in_rng) ? r_word : 64'h0;
  assign r_resp_o   = (r_valid_o && !r_in_rng) ? 2'b10 : 2'b00;
  assign r_last_o   = r_valid_o && (rcnt_q == CNT_W'(1));
  assign r_user_o   = 1'b0;

endmodule

// File: tb/tb_jtag_axi_scratch_slave.sv
// Randomized self-checking bench for jtag_axi_scratch_slave against a word-array reference model.
// Honours JTAG_SCRATCH_ID_WORD_EN in the model when the build defines it.
module tb_jtag_axi_scratch_slave;

  localparam int unsigned NW   = 16;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam logic [63:0] IDW  = 64'h4A54_4147_5343_5230;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  aw_id, ar_id, b_id, r_id;
  logic [31:0] aw_addr, ar_addr;
  logic [7:0]  aw_len, ar_len, w_strb;
  logic [1:0]  aw_burst, ar_burst, b_resp, r_resp;
  logic        aw_valid, aw_ready, w_last, w_valid, w_ready, b_valid, b_ready, b_user;
  logic        ar_valid, ar_ready, r_last, r_valid, r_ready, r_user;
  logic [63:0] w_data, r_data;

  always #5 clk = ~clk;

  jtag_axi_scratch_slave #(.NUM_WORDS(NW), .BASE_ADDR(BASE), .ID_W(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .aw_id_i(aw_id), .aw_addr_i(aw_addr), .aw_len_i(aw_len), .aw_burst_i(aw_burst),
    .aw_valid_i(aw_valid), .aw_ready_o(aw_ready),
    .w_data_i(w_data), .w_strb_i(w_strb), .w_last_i(w_last), .w_valid_i(w_valid), .w_ready_o(w_ready),
    .b_id_o(b_id), .b_resp_o(b_resp), .b_valid_o(b_valid), .b_ready_i(b_ready), .b_user_o(b_user),
    .ar_id_i(ar_id), .ar_addr_i(ar_addr), .ar_len_i(ar_len), .ar_burst_i(ar_burst),
    .ar_valid_i(ar_valid), .ar_ready_o(ar_ready),
    .r_id_o(r_id), .r_data_o(r_data), .r_resp_o(r_resp), .r_last_o(r_last), .r_valid_o(r_valid),
    .r_ready_i(r_ready), .r_user_o(r_user)
  );

  logic [63:0] mdl [NW];
  logic [63:0] wd [16];
  logic [7:0]  ws [16];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit id_word_on();
`ifdef JTAG_SCRATCH_ID_WORD_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int unsigned beat_idx(input logic [31:0] addr, input logic [1:0] burst, input int b);
    logic [31:0] off;
    off = addr - BASE;
    return (burst == 2'b00) ? int'(off >> 3) : int'(off >> 3) + b;
  endfunction

  function automatic logic [63:0] exp_rdata(input int unsigned idx);
    if (idx >= NW) return 64'h0;
    if (id_word_on() && idx == 0) return IDW;
    return mdl[idx];
  endfunction

  function automatic bit wr_ok(input int unsigned idx);
    return (idx < NW) && !(id_word_on() && idx == 0);
  endfunction

  task automatic clear_model();
    for (int i = 0; i < NW; i++) mdl[i] = 64'h0;
  endtask

  // Sends nsend beats (last on the final one) from wd/ws, then checks B.
  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input logic [1:0] burst, input int nsend, input int bhold, input bit gaps);
    bit err = 1'b0;
    int to;
    int unsigned idx;
    @(negedge clk);
    aw_id = id; aw_addr = addr; aw_len = 8'(len); aw_burst = burst; aw_valid = 1'b1;
    to = 0;
    while (!aw_ready && to < 50) begin @(negedge clk); to++; end
    check("aw_ready", 64'(aw_ready), 64'h1);
    @(negedge clk);
    aw_valid = 1'b0;
    check("w_ready_latency", 64'(w_ready), 64'h1);
    for (int b = 0; b < nsend; b++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin w_valid = 1'b0; @(negedge clk); end
      w_data = wd[b]; w_strb = ws[b]; w_last = (b == nsend - 1); w_valid = 1'b1;
      to = 0;
      while (!w_ready && to < 50) begin @(negedge clk); to++; end
      check("w_ready", 64'(w_ready), 64'h1);
      idx = beat_idx(addr, burst, b);
      if (wr_ok(idx)) begin
        for (int k = 0; k < 8; k++) if (ws[b][k]) mdl[idx][8*k +: 8] = wd[b][8*k +: 8];
      end else begin
        err = 1'b1;
      end
      @(negedge clk);
    end
    w_valid = 1'b0; w_last = 1'b0;
    if (nsend < len + 1) err = 1'b1;
    for (int h = 0; h <= bhold; h++) begin
      check("b_valid", 64'(b_valid), 64'h1);
      check("b_id", 64'(b_id), 64'(id));
      check("b_resp", 64'(b_resp), err ? 64'h2 : 64'h0);
      if (h < bhold) @(negedge clk);
    end
    b_ready = 1'b1;
    @(negedge clk);
    b_ready = 1'b0;
    check("b_done", 64'(b_valid), 64'h0);
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                         input logic [1:0] burst, input bit rand_ready);
    int to;
    int d;
    int unsigned idx;
    @(negedge clk);
    ar_id = id; ar_addr = addr; ar_len = 8'(len); ar_burst = burst; ar_valid = 1'b1;
    to = 0;
    while (!ar_ready && to < 50) begin @(negedge clk); to++; end
    check("ar_ready", 64'(ar_ready), 64'h1);
    @(negedge clk);
    ar_valid = 1'b0;
    for (int b = 0; b <= len; b++) begin
      idx = beat_idx(addr, burst, b);
      d = rand_ready ? int'($urandom_range(0, 2)) : 0;
      for (int h = 0; h <= d; h++) begin
        r_ready = (h == d);
        check("r_valid", 64'(r_valid), 64'h1);
        check("r_id", 64'(r_id), 64'(id));
        check("r_data", r_data, exp_rdata(idx));
        check("r_resp", 64'(r_resp), (idx < NW) ? 64'h0 : 64'h2);
        check("r_last", 64'(r_last), 64'(b == len));
        @(negedge clk);
      end
      r_ready = 1'b0;
    end
    check("r_done", 64'(r_valid), 64'h0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, 64'({aw_ready, w_ready, b_valid, ar_ready, r_valid, r_last, b_resp, r_resp, b_user, r_user}), 64'h0);
    check({tag, "_ids"}, 64'({b_id, r_id}), 64'h0);
    check({tag, "_rdata"}, r_data, 64'h0);
  endtask

  initial begin
    rst = 1'b1;
    aw_id = '0; aw_addr = '0; aw_len = '0; aw_burst = 2'b01; aw_valid = 1'b0;
    ar_id = '0; ar_addr = '0; ar_len = '0; ar_burst = 2'b01; ar_valid = 1'b0;
    w_data = '0; w_strb = '0; w_last = 1'b0; w_valid = 1'b0; b_ready = 1'b0; r_ready = 1'b0;
    clear_model();
    #1;
    check_all_zero("reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("aw_ready_after_reset", 64'(aw_ready), 64'h1);
    check("ar_ready_after_reset", 64'(ar_ready), 64'h1);

    // single write then read back
    wd[0] = 64'h1122334455667788; ws[0] = 8'hFF;
    do_write(4'h5, 32'h18, 0, 2'b01, 1, 0, 1'b0);
    do_read(4'h9, 32'h18, 0, 2'b01, 1'b0);
    check("word3_value", mdl[3], 64'h1122334455667788);

    // partial strobe
    wd[0] = 64'hFFFF_FFFF_FFFF_FFFF; ws[0] = 8'hFF;
    do_write(4'h1, 32'h08, 0, 2'b01, 1, 0, 1'b0);
    wd[0] = 64'h0; ws[0] = 8'h0F;
    do_write(4'h2, 32'h08, 0, 2'b01, 1, 0, 1'b0);
    do_read(4'h3, 32'h08, 0, 2'b01, 1'b0);
    check("partial_strobe_model", mdl[1], 64'hFFFF_FFFF_0000_0000);

    // INCR burst running off the top of the bank
    for (int b = 0; b < 4; b++) begin wd[b] = {$urandom, $urandom}; ws[b] = 8'hFF; end
    do_write(4'h7, 32'h70, 3, 2'b01, 4, 0, 1'b0);
    do_read(4'h8, 32'h70, 3, 2'b01, 1'b0);

    // B backpressure with a concurrent read accepted during the pending response
    for (int b = 0; b < 2; b++) begin wd[b] = {$urandom, $urandom}; ws[b] = 8'hFF; end
    fork
      do_write(4'hA, 32'h20, 1, 2'b01, 2, 5, 1'b0);
      begin
        repeat (4) @(negedge clk);
        do_read(4'hB, 32'h50, 3, 2'b01, 1'b1);
      end
    join

    // word 0: ID constant or ordinary scratch
    wd[0] = 64'hDEAD_BEEF_0BAD_F00D; ws[0] = 8'hFF;
    do_write(4'h4, 32'h00, 0, 2'b01, 1, 0, 1'b0);
    do_read(4'h6, 32'h00, 0, 2'b01, 1'b0);

    // reset in the middle of a 4-beat write
    @(negedge clk);
    aw_id = 4'hC; aw_addr = 32'h40; aw_len = 8'd3; aw_burst = 2'b01; aw_valid = 1'b1;
    @(negedge clk);
    aw_valid = 1'b0;
    for (int b = 0; b < 2; b++) begin
      w_data = {$urandom, $urandom}; w_strb = 8'hFF; w_last = 1'b0; w_valid = 1'b1;
      @(negedge clk);
    end
    #2 rst = 1'b1;
    #1;
    check_all_zero("mid_reset");
    w_valid = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("aw_ready_release", 64'(aw_ready), 64'h1);
    check("b_valid_release", 64'(b_valid), 64'h0);
    do_read(4'hD, 32'h00, 15, 2'b01, 1'b0);

    // randomized traffic
    for (int t = 0; t < 60; t++) begin
      logic [31:0] addr;
      logic [1:0]  burst;
      int len;
      addr  = 32'($urandom_range(0, 19) * 8 + $urandom_range(0, 7));
      burst = 2'($urandom_range(0, 2));
      len   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) begin
        int nsend;
        for (int b = 0; b < 16; b++) begin wd[b] = {$urandom, $urandom}; ws[b] = 8'($urandom); end
        nsend = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, len + 1)) : len + 1;
        do_write(4'($urandom), addr, len, burst, nsend, int'($urandom_range(0, 3)), 1'b1);
      end else begin
        do_read(4'($urandom), addr, len, burst, 1'b1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/jtag_axi_scratch_slave.md
Name: jtag_axi_scratch_slave

Overview:
- AXI4 responder (slave end) for 64-bit single-beat and short-burst traffic issued by the JTAG AXI master.
- Holds a small 64-bit-wide scratch register bank that JTAG can write and read back.
- Sits on a slave port of the SoC AXI interconnect, or connects point-to-point to the JTAG master for bring-up and debug loopback.
- Read and write channels are handled by two independent state machines.

Parameters:
- NUM_WORDS, 16, number of 64-bit scratch words. Power of two, 2..256.
- BASE_ADDR, 32'h0000_0000, byte base address of word 0. Must be 8-byte aligned.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- axi_slave  AXI_BUS.Slave  -  64-bit data, 32-bit address.
  - Inputs used: aw_id/addr/len/burst/valid, w_data/strb/last/valid, b_ready, ar_id/addr/len/burst/valid, r_ready.
  - Outputs driven: aw_ready, w_ready, b_id/resp/valid, ar_ready, r_id/data/resp/last/valid.
  - b_user and r_user are driven 0.
  - aw/ar size, lock, cache, prot, region, user and qos inputs are ignored.

Behaviour:
- Decided interface: one clock, clk_i; asynchronous, active-high reset rst_i.
- While rst_i is high:
  - Both FSMs are forced to their idle state and all scratch words clear to 0.
  - All slave outputs are 0, including aw_ready and ar_ready.
  - These take effect immediately, not on a clock edge.
  - A transaction in flight when reset asserts is abandoned; no B or R response is sent for it.
- Address decode:
  - off = addr - BASE_ADDR; addr[2:0] is ignored.
  - idx = off[31:3]. The beat is in range when idx < NUM_WORDS.
  - Every beat is 8 bytes regardless of aw_size/ar_size.
- Burst handling:
  - Beats per transaction = len + 1 (1..16).
  - FIXED (2'b00): the same idx for every beat.
  - INCR (2'b01) and WRAP (2'b10): idx + 1 per beat. WRAP is treated as INCR.
  - An INCR burst running past the top word makes the remaining beats out of range. There is no wrap-around to word 0.
- Write FSM:
  - W_IDLE: aw_ready=1. On the aw handshake, latch id, idx, beat count and burst, then go to W_DATA.
  - W_DATA: w_ready=1. On each w handshake:
    - In range: write the byte lanes where w_strb=1; other lanes keep their value.
    - Out of range: data is dropped and a sticky slverr flag is set.
    - The transaction ends on w_last or on the final counted beat, whichever comes first. Go to W_RESP.
    - If w_last arrives before the count completes, the sticky flag is also set.
  - W_RESP: b_valid=1, b_id = latched id, b_resp = 2'b10 if the sticky flag is set, else 2'b00. Hold until b_ready, then go to W_IDLE and clear the flag.
  - Latency: w_ready is high the cycle after the aw handshake. b_valid is high the cycle after the last w handshake.
- Read FSM:
  - R_IDLE: ar_ready=1. On the ar handshake, latch id, idx, count and burst, then go to R_DATA.
  - R_DATA: r_valid=1, r_id = latched id.
    - r_data = mem[idx], read combinationally from current contents; 0 when out of range.
    - r_resp = 2'b10 when out of range, else 2'b00.
    - r_last=1 on the final beat.
    - Each r handshake advances idx and decrements the count. After the last beat, go to R_IDLE.
  - Latency: first r_valid is high the cycle after the ar handshake. With r_ready held high, one beat per cycle.
- Simultaneous events:
  - Read and write run concurrently.
  - A write committed on edge N is visible on r_data from cycle N+1.
  - A same-cycle w handshake and r beat to the same word return the old data.
- Outputs are held stable while valid is high and ready is low (AXI rule).

Optional Feature:
- Macro: JTAG_SCRATCH_ID_WORD_EN.
- Defined:
  - Word 0 is a read-only identification constant, 64'h4A54_4147_5343_5230.
  - Reset does not change it.
  - A write beat hitting word 0 is dropped and sets the slverr flag.
  - Reads of word 0 return the constant with OKAY.
- Undefined: word 0 is an ordinary read/write scratch word.

Test Plan:
- Reset then single write: AW addr 0x18, len 0; W data 0x1122334455667788, strb 0xFF, last=1 -> b_valid one cycle after the W handshake, b_resp=00, b_id echoes aw_id. Read of 0x18 -> r_data 0x1122334455667788, r_last=1, r_resp=00.
- Partial strobe: write 0xFFFF_FFFF_FFFF_FFFF to 0x08, then 0x0 with strb 0x0F -> read returns 0xFFFF_FFFF_0000_0000.
- INCR burst: len=3 from word 14 with NUM_WORDS=16 -> words 14 and 15 written, beats 3 and 4 dropped, b_resp=10. Read burst len=3 -> r_resp 00,00,10,10; r_data 0 on the last two beats; r_last only on beat 4.
- Backpressure: b_ready=0 for 5 cycles and r_ready toggling -> b_valid, b_id, r_data and r_last hold stable. No beat is lost or duplicated. A concurrent AR is accepted during a pending B.
- Reset mid-burst: rst_i asserted after 2 of 4 W beats -> all outputs 0 immediately, memory reads 0 after release, aw_ready=1 the first cycle after release.
- With JTAG_SCRATCH_ID_WORD_EN: write to 0x00 -> b_resp=10. Read 0x00 -> 0x4A54_4147_5343_5230 with OKAY. Without the macro: the write reads back with OKAY.
